// File: rtl/usb_slave_fifo_responder.sv
// -----------------------------------------------------------------------------
// usb_slave_fifo_responder
//
// Device-side target for a 16-bit synchronous slave-FIFO bus. It holds two
// word FIFOs:
//   EP2 (OUT, ep=00): the host side fills it and the bus master reads it.
//   EP6 (IN,  ep=10): the bus master writes it and the host side drains it.
//                     Words become visible to the host only once their
//                     packet is committed, either automatically at
//                     PKT_WORDS or by a pkt_end strobe.
//
// Ports
//   clk, rst                 clock and asynchronous active-low reset
//   usb_data                 bidirectional bus data; driven only for EP2 reads
//   addr0, addr1             endpoint select, ep = {addr1, addr0}
//   cs, wr, rd, oe, pkt_end  active-low bus strobes
//   flag_empty, flag_full    status of the addressed endpoint
//   h_out_*                  host-side push interface into EP2
//   h_in_*                   host-side pop interface out of EP6
//   err_ovf, err_udf         sticky overflow / underflow indicators
// -----------------------------------------------------------------------------
module usb_slave_fifo_responder #(
    parameter int DEPTH     = 512,
    parameter int AW        = 9,
    parameter int PKT_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] usb_data,
    input  logic        addr0,
    input  logic        addr1,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic        oe,
    input  logic        pkt_end,
    output logic        flag_empty,
    output logic        flag_full,
    input  logic [15:0] h_out_data,
    input  logic        h_out_valid,
    output logic        h_out_ready,
    output logic [15:0] h_in_data,
    output logic        h_in_valid,
    output logic        h_in_last,
    input  logic        h_in_ready,
    output logic        err_ovf,
    output logic        err_udf
);

    localparam logic [1:0]  EP_OUT  = 2'b00;
    localparam logic [1:0]  EP_IN   = 2'b10;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] PKT_C   = (AW+1)'(PKT_WORDS);

    // ------------------------------------------------------------------
    // Endpoint decode
    // ------------------------------------------------------------------
    logic [1:0] ep;
    logic       sel_out;
    logic       sel_in;

    assign ep      = {addr1, addr0};
    assign sel_out = !cs && (ep == EP_OUT);
    assign sel_in  = !cs && (ep == EP_IN);

    // ------------------------------------------------------------------
    // EP2 (OUT) FIFO
    // ------------------------------------------------------------------
    logic [15:0]   out_mem [DEPTH];
    logic [AW-1:0] out_wptr_q, out_wptr_d;
    logic [AW-1:0] out_rptr_q, out_rptr_d;
    logic [AW:0]   out_cnt_q,  out_cnt_d;
    logic          out_empty;
    logic          out_full;
    logic [15:0]   out_head;
    logic          bus_rd_req;
    logic          out_pop;
    logic          out_push;
    logic          udf_evt;

    assign out_empty  = (out_cnt_q == '0);
    assign out_full   = (out_cnt_q == DEPTH_C);
    // First-word-fall-through head; reads as zero when nothing is queued.
    assign out_head   = out_empty ? 16'h0000 : out_mem[out_rptr_q];
    assign bus_rd_req = sel_out && !rd;
    assign out_pop    = bus_rd_req && !out_empty;
    assign udf_evt    = bus_rd_req && out_empty;
    assign out_push   = h_out_valid && !out_full;

    always_comb begin
        out_wptr_d = out_wptr_q;
        out_rptr_d = out_rptr_q;
        out_cnt_d  = out_cnt_q;
        if (out_push) out_wptr_d = out_wptr_q + AW'(1);
        if (out_pop)  out_rptr_d = out_rptr_q + AW'(1);
        // Simultaneous push and pop leaves the count unchanged.
        if (out_push && !out_pop)      out_cnt_d = out_cnt_q + (AW+1)'(1);
        else if (out_pop && !out_push) out_cnt_d = out_cnt_q - (AW+1)'(1);
    end

    // The bus is released while reset is held, independent of the strobes.
    assign usb_data = (rst && sel_out && !oe) ? out_head : 16'bz;

    // ------------------------------------------------------------------
    // EP6 (IN) FIFO with packet commit
    // ------------------------------------------------------------------
    logic [15:0]      in_mem [DEPTH];
    logic [DEPTH-1:0] in_last_q;
    logic [AW-1:0]    in_wptr_q, in_wptr_d;
    logic [AW-1:0]    in_rptr_q, in_rptr_d;
    logic [AW:0]      in_ccnt_q, in_ccnt_d;
    logic [AW:0]      in_ucnt_q, in_ucnt_d;
    logic [AW:0]      in_cnt;
    logic [AW:0]      ucnt_after;
    logic             in_full;
    logic             bus_wr_req;
    logic             in_push;
    logic             in_pop;
    logic             ovf_evt;
    logic             commit;
    logic [AW-1:0]    last_idx;

    assign in_cnt     = in_ccnt_q + in_ucnt_q;
    assign in_full    = (in_cnt == DEPTH_C);
    assign bus_wr_req = sel_in && !wr;
    assign in_push    = bus_wr_req && !in_full;
    assign ovf_evt    = bus_wr_req && in_full;
    assign h_in_valid = (in_ccnt_q != '0);
    assign in_pop     = h_in_valid && h_in_ready;

    // Commit decisions look at the uncommitted count including this cycle's
    // push, so a word written alongside pkt_end closes the packet it joins.
    assign ucnt_after = in_ucnt_q + (AW+1)'(in_push);
    assign commit     = (ucnt_after == PKT_C) ||
                        (sel_in && !pkt_end && (ucnt_after != '0));
    assign last_idx   = in_push ? in_wptr_q : (in_wptr_q - AW'(1));

    always_comb begin
        in_wptr_d = in_wptr_q;
        in_rptr_d = in_rptr_q;
        in_ccnt_d = in_ccnt_q - (AW+1)'(in_pop);
        in_ucnt_d = ucnt_after;
        if (in_push) in_wptr_d = in_wptr_q + AW'(1);
        if (in_pop)  in_rptr_d = in_rptr_q + AW'(1);
        if (commit) begin
            in_ccnt_d = in_ccnt_d + ucnt_after;
            in_ucnt_d = '0;
        end
    end

    assign h_in_data = h_in_valid ? in_mem[in_rptr_q] : 16'h0000;
    assign h_in_last = h_in_valid && in_last_q[in_rptr_q];

    // ------------------------------------------------------------------
    // Flags and host-side ready
    // ------------------------------------------------------------------
    assign flag_empty  = (ep == EP_OUT) ? out_empty : 1'b1;
    assign flag_full   = (ep == EP_IN)  ? in_full   : 1'b1;
    assign h_out_ready = !out_full;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic err_ovf_q;
    logic err_udf_q;

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_ccnt_q  <= '0;
            in_ucnt_q  <= '0;
            in_last_q  <= '0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
        end else begin
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_ccnt_q  <= in_ccnt_d;
            in_ucnt_q  <= in_ucnt_d;
            // A freshly pushed word starts as not-last; a commit in the same
            // cycle marks it (the second assignment wins on the same index).
            if (in_push) in_last_q[in_wptr_q] <= 1'b0;
            if (commit)  in_last_q[last_idx]  <= 1'b1;
            if (ovf_evt) err_ovf_q <= 1'b1;
            if (udf_evt) err_udf_q <= 1'b1;
        end
    end

    // Word storage carries no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wptr_q] <= h_out_data;
        if (in_push)  in_mem[in_wptr_q]   <= usb_data;
    end

endmodule

// File: tb/tb_usb_slave_fifo_responder.sv
// -----------------------------------------------------------------------------
// Bench for usb_slave_fifo_responder. A queue-based model tracks the two
// endpoints; a negedge process compares every output against it, and the
// directed sequences add literal expectations of their own.
// usb_data is a pulled-up net, so an undriven bus reads as 16'hFFFF.
// -----------------------------------------------------------------------------
module tb_usb_slave_fifo_responder;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int PKT   = 256;

    logic        clk = 1'b0;
    logic        rst;
    tri1  [15:0] usb_data;
    logic [15:0] tb_drv;
    logic        tb_en;
    logic        addr0, addr1, cs, wr, rd, oe, pkt_end;
    logic        flag_empty, flag_full;
    logic [15:0] h_out_data;
    logic        h_out_valid, h_out_ready;
    logic [15:0] h_in_data;
    logic        h_in_valid, h_in_last, h_in_ready;
    logic        err_ovf, err_udf;

    always #5 clk = ~clk;

    assign usb_data = tb_en ? tb_drv : 16'bz;

    usb_slave_fifo_responder #(.DEPTH(DEPTH), .AW(AW), .PKT_WORDS(PKT)) dut (
        .clk(clk), .rst(rst), .usb_data(usb_data),
        .addr0(addr0), .addr1(addr1), .cs(cs), .wr(wr), .rd(rd), .oe(oe),
        .pkt_end(pkt_end), .flag_empty(flag_empty), .flag_full(flag_full),
        .h_out_data(h_out_data), .h_out_valid(h_out_valid), .h_out_ready(h_out_ready),
        .h_in_data(h_in_data), .h_in_valid(h_in_valid), .h_in_last(h_in_last),
        .h_in_ready(h_in_ready), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    // ---------------- model ----------------
    logic [15:0] m_out[$];
    logic [15:0] m_unc[$];
    logic [16:0] m_com[$];   // {last, data}
    bit          m_ovf, m_udf;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_clear();
        m_out.delete();
        m_unc.delete();
        m_com.delete();
        m_ovf = 0;
        m_udf = 0;
    endfunction

    // Applies one rising edge using the inputs that were held before it.
    task automatic m_edge();
        logic [1:0] ep;
        int osz, csz, icnt, n;
        ep   = {addr1, addr0};
        osz  = m_out.size();
        csz  = m_com.size();
        icnt = csz + m_unc.size();
        if (!rst) begin
            m_clear();
            return;
        end
        if (!cs && !rd && ep == 2'b00) begin
            if (osz > 0) void'(m_out.pop_front());
            else m_udf = 1;
        end
        if (h_out_valid && osz < DEPTH) m_out.push_back(h_out_data);
        if (csz > 0 && h_in_ready) void'(m_com.pop_front());
        if (!cs && !wr && ep == 2'b10) begin
            if (icnt < DEPTH) m_unc.push_back(tb_drv);
            else m_ovf = 1;
        end
        n = m_unc.size();
        if (n == PKT || (!cs && !pkt_end && ep == 2'b10 && n > 0)) begin
            for (int i = 0; i < n; i++) m_com.push_back({(i == n - 1), m_unc[i]});
            m_unc.delete();
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic [1:0]  c_ep;
    logic [15:0] c_bus;

    always @(negedge clk) begin
        if (chk_en) begin
            c_ep = {addr1, addr0};
            if (rst && !cs && !oe && c_ep == 2'b00)
                c_bus = (m_out.size() > 0) ? m_out[0] : 16'h0000;
            else if (tb_en)
                c_bus = tb_drv;
            else
                c_bus = 16'hFFFF;
            chk("bus", usb_data, c_bus);
            chk("flag_empty", flag_empty, (c_ep == 2'b00) ? (m_out.size() == 0) : 1'b1);
            chk("flag_full", flag_full,
                (c_ep == 2'b10) ? ((m_com.size() + m_unc.size()) == DEPTH) : 1'b1);
            chk("h_out_ready", h_out_ready, m_out.size() < DEPTH);
            chk("h_in_valid", h_in_valid, m_com.size() > 0);
            if (m_com.size() > 0) begin
                chk("h_in_data", h_in_data, m_com[0][15:0]);
                chk("h_in_last", h_in_last, m_com[0][16]);
            end
            chk("err_ovf", err_ovf, m_ovf);
            chk("err_udf", err_udf, m_udf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        cs = 1; wr = 1; rd = 1; oe = 1; pkt_end = 1;
        addr0 = 0; addr1 = 0;
        h_out_valid = 0; h_in_ready = 0; tb_en = 0;
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [8:0] rnd;
        idle();
        rst = 0; tb_drv = 16'h0; h_out_data = 16'h0;
        m_clear();
        chk_en = 1;

        // Reset held with random strobes
        for (int k = 0; k < 6; k++) begin
            rnd = 9'($urandom);
            {cs, wr, rd, oe, pkt_end, addr0, addr1, h_out_valid, h_in_ready} = rnd;
            h_out_data = 16'($urandom);
            step();
        end
        cs = 0; oe = 0; addr0 = 0; addr1 = 0; wr = 1; rd = 0;
        #1;
        chk("rst_bus_z", usb_data, 16'hFFFF);
        chk("rst_h_in_valid", h_in_valid, 0);
        chk("rst_h_out_ready", h_out_ready, 1);
        chk("rst_flag_empty", flag_empty, 1);
        addr1 = 1;
        #1;
        chk("rst_flag_full_ep6", flag_full, 0);
        idle();
        rst = 1;
        repeat (3) step();
        chk("post_rst_err_udf", err_udf, 0);
        chk("post_rst_err_ovf", err_ovf, 0);

        // Host loads EP2, master reads it out, then underflows
        h_out_valid = 1;
        h_out_data = 16'h1111; step();
        h_out_data = 16'h2222; step();
        h_out_data = 16'h3333; step();
        h_out_valid = 0;
        cs = 0; oe = 0; rd = 0;
        #1;
        chk("t2_w0", usb_data, 16'h1111);
        step(); chk("t2_w1", usb_data, 16'h2222);
        step(); chk("t2_w2", usb_data, 16'h3333);
        step();
        chk("t2_empty_bus", usb_data, 16'h0000);
        chk("t2_flag_empty", flag_empty, 1);
        chk("t2_no_udf_yet", err_udf, 0);
        step();
        chk("t2_udf", err_udf, 1);
        chk("t2_bus_zero", usb_data, 16'h0000);
        idle();
        step();

        // Short packet closed by pkt_end on its last word
        cs = 0; wr = 0; addr1 = 1; tb_en = 1;
        for (int i = 0; i < 5; i++) begin
            tb_drv = 16'hA000 + 16'(i);
            pkt_end = (i == 4) ? 1'b0 : 1'b1;
            step();
            chk("t3_valid_latency", h_in_valid, (i == 4));
        end
        idle();
        h_in_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_data", h_in_data, 16'hA000 + 16'(i));
            chk("t3_last", h_in_last, (i == 4));
            step();
        end
        chk("t3_drained", h_in_valid, 0);
        idle();
        step();

        // Auto commit at PKT words, then an ignored empty pkt_end
        cs = 0; wr = 0; addr1 = 1; tb_en = 1;
        for (int i = 0; i < PKT; i++) begin
            tb_drv = 16'hB000 + 16'(i);
            step();
            if (i == PKT - 2) chk("t4_not_yet", h_in_valid, 0);
        end
        chk("t4_auto_commit", h_in_valid, 1);
        tb_en = 0; wr = 1; pkt_end = 0;
        step();
        idle();
        h_in_ready = 1;
        for (int i = 0; i < PKT; i++) begin
            #1;
            chk("t4_data", h_in_data, 16'hB000 + 16'(i));
            chk("t4_last", h_in_last, (i == PKT - 1));
            step();
        end
        chk("t4_no_extra_pkt", h_in_valid, 0);
        idle();
        step();

        // Fill EP6 to DEPTH, overflow, then drain
        cs = 0; wr = 0; addr1 = 1; tb_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tb_drv = 16'hC000 + 16'(i);
            step();
        end
        chk("t5_full", flag_full, 1);
        chk("t5_no_ovf_yet", err_ovf, 0);
        tb_drv = 16'hDEAD;
        step();
        chk("t5_ovf", err_ovf, 1);
        chk("t5_still_full", flag_full, 1);
        tb_en = 0; wr = 1; addr1 = 0;
        #1;
        chk("t5_unaddr_full", flag_full, 1);
        idle();
        h_in_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("t5_data", h_in_data, 16'hC000 + 16'(i));
            chk("t5_last", h_in_last, (i == PKT - 1) || (i == DEPTH - 1));
            step();
        end
        chk("t5_drained", h_in_valid, 0);
        idle();
        step();

        // Concurrent host push and bus pop at occupancy 1, reset mid-stream
        h_out_valid = 1; h_out_data = 16'hD000;
        step();
        cs = 0; oe = 0; rd = 0;
        for (int i = 0; i < 10; i++) begin
            h_out_data = 16'hD001 + 16'(i);
            #1;
            chk("t6_bus", usb_data, 16'hD000 + 16'(i));
            chk("t6_not_empty", flag_empty, 0);
            if (i == 6) begin
                rst = 0;
                m_clear();
                #1;
                chk("t6_async_z", usb_data, 16'hFFFF);
                chk("t6_async_empty", flag_empty, 1);
                chk("t6_async_udf_clr", err_udf, 0);
                break;
            end
            step();
        end
        step();
        step();
        idle();
        rst = 1;
        step();
        chk("t6_post_bus_z", usb_data, 16'hFFFF);
        chk("t6_post_empty", flag_empty, 1);
        chk("t6_post_ovf_clr", err_ovf, 0);
        step();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
